// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU constants and request/response bundles for the CV32E40P APU
// interface, including the FPU arbiter's default outstanding depth.
package cv32e40p_apu_core_pkg;

    localparam int unsigned APU_NARGS_CPU       = 3;
    localparam int unsigned APU_WOP_CPU         = 6;
    localparam int unsigned APU_NDSFLAGS_CPU    = 15;
    localparam int unsigned APU_NUSFLAGS_CPU    = 5;
    localparam int unsigned APU_MAX_OUTSTANDING = 4;

    typedef struct packed {
        logic [APU_NARGS_CPU-1:0][31:0] operands;
        logic [APU_WOP_CPU-1:0]         op;
        logic [APU_NDSFLAGS_CPU-1:0]    flags;
    } apu_req_t;

    typedef struct packed {
        logic [31:0]                 result;
        logic [APU_NUSFLAGS_CPU-1:0] rflags;
    } apu_rsp_t;

endpackage

// File: rtl/cv32e40p_apu_id_fifo.sv
// In-order FIFO of requester IDs for operations in flight inside the FPU;
// the head names the core that owns the next returning result.
module cv32e40p_apu_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; only entries behind a valid count are ever read.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one FPU wrapper between several cores' APU
// ports; selection is locked while a request waits for the FPU grant.
module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = APU_MAX_OUTSTANDING,
    parameter int unsigned NARGS           = APU_NARGS_CPU,
    parameter int unsigned WOP             = APU_WOP_CPU,
    parameter int unsigned NDSFLAGS        = APU_NDSFLAGS_CPU,
    parameter int unsigned NUSFLAGS        = APU_NUSFLAGS_CPU
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_apu_req_i,
    output logic [NUM_REQ-1:0]                  req_apu_gnt_o,
    input  logic [NUM_REQ-1:0][NARGS-1:0][31:0] req_apu_operands_i,
    input  logic [NUM_REQ-1:0][WOP-1:0]         req_apu_op_i,
    input  logic [NUM_REQ-1:0][NDSFLAGS-1:0]    req_apu_flags_i,
    output logic [NUM_REQ-1:0]                  req_apu_rvalid_o,
    output logic [31:0]                         req_apu_result_o,
    output logic [NUSFLAGS-1:0]                 req_apu_rflags_o,
    output logic                                fpu_req_o,
    input  logic                                fpu_gnt_i,
    output logic [NARGS-1:0][31:0]              fpu_operands_o,
    output logic [WOP-1:0]                      fpu_op_o,
    output logic [NDSFLAGS-1:0]                 fpu_flags_o,
    input  logic                                fpu_rvalid_i,
    input  logic [31:0]                         fpu_rdata_i,
    input  logic [NUSFLAGS-1:0]                 fpu_rflags_i,
    output logic                                busy_o,
    output logic                                err_o
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;

    logic [ID_W-1:0] winner;
    logic            found;
    logic            issue;
    logic            pop;
    logic [ID_W-1:0] head;
    logic            full;
    logic            empty;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (locked_q) begin
            winner = lock_id_q;
            found  = req_apu_req_i[lock_id_q];
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                // Scanning downward lets the first hit from rr_ptr win last.
                automatic int unsigned k = (int'(rr_ptr_q) + i) % NUM_REQ;
                if (req_apu_req_i[k]) begin
                    winner = ID_W'(k);
                    found  = 1'b1;
                end
            end
        end
    end

    assign fpu_req_o      = found && !full;
    assign issue          = fpu_req_o && fpu_gnt_i;
    assign pop            = fpu_rvalid_i && !empty;
    assign fpu_operands_o = req_apu_operands_i[winner];
    assign fpu_op_o       = req_apu_op_i[winner];
    assign fpu_flags_o    = req_apu_flags_i[winner];

    always_comb begin
        req_apu_gnt_o            = '0;
        req_apu_gnt_o[winner]    = issue;
        req_apu_rvalid_o         = '0;
        req_apu_rvalid_o[head]   = pop;
    end

    assign req_apu_result_o = fpu_rdata_i;
    assign req_apu_rflags_o = fpu_rflags_i;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        err_d     = err_q | (fpu_rvalid_i && empty);
        if (issue) begin
            rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            locked_d = 1'b0;
        end else if (fpu_req_o) begin
            locked_d  = 1'b1;
            lock_id_d = winner;
        end else if (locked_q && !req_apu_req_i[lock_id_q]) begin
            // A locked requester that withdraws must not starve the others.
            locked_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
        end
    end

    cv32e40p_apu_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue),
        .data_i  (winner),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign busy_o = !empty || fpu_req_o;
    assign err_o  = err_q;

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for the two-core APU arbiter: round-robin order, lock,
// full FIFO, concurrent push/pop, stray rvalid and mid-flight reset.
module tb_cv32e40p_apu_arbiter;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned NARGS    = 3;
    localparam int unsigned WOP      = 6;
    localparam int unsigned NDSFLAGS = 15;
    localparam int unsigned NUSFLAGS = 5;

    logic                                clk = 1'b0;
    logic                                rst_i;
    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ-1:0]                  gnt;
    logic [NUM_REQ-1:0][NARGS-1:0][31:0] operands;
    logic [NUM_REQ-1:0][WOP-1:0]         op;
    logic [NUM_REQ-1:0][NDSFLAGS-1:0]    flags;
    logic [NUM_REQ-1:0]                  rvalid;
    logic [31:0]                         result;
    logic [NUSFLAGS-1:0]                 rflags;
    logic                                fpu_req;
    logic                                fpu_gnt;
    logic [NARGS-1:0][31:0]              fpu_operands;
    logic [WOP-1:0]                      fpu_op;
    logic [NDSFLAGS-1:0]                 fpu_flags;
    logic                                fpu_rvalid;
    logic [31:0]                         fpu_rdata;
    logic [NUSFLAGS-1:0]                 fpu_rflags;
    logic                                busy;
    logic                                err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cv32e40p_apu_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .MAX_OUTSTANDING (4),
        .NARGS           (NARGS),
        .WOP             (WOP),
        .NDSFLAGS        (NDSFLAGS),
        .NUSFLAGS        (NUSFLAGS)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .req_apu_req_i      (req),
        .req_apu_gnt_o      (gnt),
        .req_apu_operands_i (operands),
        .req_apu_op_i       (op),
        .req_apu_flags_i    (flags),
        .req_apu_rvalid_o   (rvalid),
        .req_apu_result_o   (result),
        .req_apu_rflags_o   (rflags),
        .fpu_req_o          (fpu_req),
        .fpu_gnt_i          (fpu_gnt),
        .fpu_operands_o     (fpu_operands),
        .fpu_op_o           (fpu_op),
        .fpu_flags_o        (fpu_flags),
        .fpu_rvalid_i       (fpu_rvalid),
        .fpu_rdata_i        (fpu_rdata),
        .fpu_rflags_i       (fpu_rflags),
        .busy_o             (busy),
        .err_o              (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; checks run 1 ns later.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic g, input logic v, input logic [31:0] d);
        req        = r;
        fpu_gnt    = g;
        fpu_rvalid = v;
        fpu_rdata  = d;
        fpu_rflags = d[4:0];
        #1;
    endtask

    initial begin
        for (int c = 0; c < NUM_REQ; c++) begin
            for (int a = 0; a < NARGS; a++) operands[c][a] = 32'h1000 * (c + 1) + a;
            op[c]    = WOP'(c + 5);
            flags[c] = NDSFLAGS'(c + 'h100);
        end
        rst_i = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_fpu_req", fpu_req, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        next();
        rst_i = 1'b0;

        // Round robin with constant grant: 0,1,0,1, then FIFO full.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'b1, 1'b0, 32'h0);
            check($sformatf("rr_gnt%0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_opnd%0d", i), fpu_operands[0], (i % 2 == 0) ? 32'h1000 : 32'h2000);
            check($sformatf("rr_op%0d", i), fpu_op, (i % 2 == 0) ? 6 'd5 : 6'd6);
            next();
        end
        check("full_count", dut.u_id_fifo.count_q, 4);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("full_fpu_req", fpu_req, 0);
        check("full_gnt", gnt, 0);
        check("full_busy", busy, 1);
        next();
        // Pop while full: result goes to fifo[0] = core 0, no same-cycle grant.
        drive(2'b11, 1'b1, 1'b1, 32'hCAFE0000);
        check("full_pop_rvalid", rvalid, 2'b01);
        check("full_pop_result", result, 32'hCAFE0000);
        check("full_pop_rflags", rflags, 5'h00);
        check("full_pop_fpu_req", fpu_req, 0);
        check("full_pop_gnt", gnt, 0);
        next();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("unblock_fpu_req", fpu_req, 1);
        check("unblock_gnt", gnt, 2'b01);
        next();
        // FIFO now holds 1,0,1,0.
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 1'b0, 1'b1, 32'h100 + i);
            check($sformatf("drain_rvalid%0d", i), rvalid, (i % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("drain_result%0d", i), result, 32'h100 + i);
            next();
        end
        check("drain_count", dut.u_id_fifo.count_q, 0);

        // rr_ptr = 1: core 0 alone, then core 1 alone -> FIFO 0,1.
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("pp_setup_gnt0", gnt, 2'b01);
        next();
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        check("pp_setup_gnt1", gnt, 2'b10);
        next();
        drive(2'b01, 1'b1, 1'b1, 32'h55);
        check("pp_gnt", gnt, 2'b01);
        check("pp_rvalid_old_head", rvalid, 2'b01);
        next();
        check("pp_count", dut.u_id_fifo.count_q, 2);
        drive(2'b00, 1'b0, 1'b1, 32'h56);
        check("pp_drain0", rvalid, 2'b10);
        next();
        drive(2'b00, 1'b0, 1'b1, 32'h57);
        check("pp_drain1", rvalid, 2'b01);
        next();

        // rr_ptr = 1; one issue from core 1 brings it to 0 for the lock test.
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        check("lk_setup_gnt", gnt, 2'b10);
        next();
        drive(2'b00, 1'b0, 1'b1, 32'h58);
        check("lk_setup_rvalid", rvalid, 2'b10);
        next();
        check("lk_rr_ptr0", dut.rr_ptr_q, 0);
        for (int i = 0; i < 3; i++) begin
            drive((i == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, 32'h0);
            check($sformatf("lk_opnd%0d", i), fpu_operands[2], 32'h2002);
            check($sformatf("lk_flags%0d", i), fpu_flags, 15'h101);
            check($sformatf("lk_gnt%0d", i), gnt, 0);
            next();
        end
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("lk_grant", gnt, 2'b10);
        next();
        check("lk_rr_ptr_after", dut.rr_ptr_q, 0);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("lk_next_gnt", gnt, 2'b01);
        next();
        drive(2'b00, 1'b0, 1'b1, 32'h59);
        check("lk_drain0", rvalid, 2'b10);
        next();
        drive(2'b00, 1'b0, 1'b1, 32'h5A);
        check("lk_drain1", rvalid, 2'b01);
        next();

        // Stray rvalid on empty FIFO.
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD);
        check("stray_rvalid", rvalid, 0);
        check("stray_err_pre", err, 0);
        next();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("stray_err", err, 1);
        next();
        next();
        check("stray_err_held", err, 1);

        // Three in flight, then asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 1'b1, 1'b0, 32'h0);
            next();
        end
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("inflight_busy", busy, 1);
        #1;
        rst_i = 1'b1;
        #1;
        check("rst_mid_count", dut.u_id_fifo.count_q, 0);
        check("rst_mid_fpu_req", fpu_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rr_ptr", dut.rr_ptr_q, 0);
        check("rst_mid_err", err, 0);
        next();
        rst_i = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 32'h77);
        check("late_rvalid", rvalid, 0);
        next();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("late_err", err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
